sub_bytes_iter: RTL and testbench

//  Iterative AES SubBytes stage. Accepts a 128-bit state and substitutes all 16

---
 rtl/sub_bytes_iter.sv | 140 ++++++++++++++
 tb/tb_sub_bytes_iter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: LANES shared sboxes substitute a 128-bit state
// over 16/LANES passes, with valid/ready handshakes on both sides.

module sub_bytes_sbox (
    input  logic [7:0] a,
    output logic [7:0] c
);
    // Forward AES sbox, entry 0x00 in the most significant byte.
    localparam logic [2047:0] TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign c = TBL[{~a, 3'b111} -: 8];
endmodule

module sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int NPASS = 16 / LANES;
    localparam int CW    = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NPASS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
          LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [127:0]  work_q;
    logic [127:0]  work_d;
    logic [127:0]  out_state_q;
    logic          out_valid_q;
    logic          in_ready_q;
    logic          busy_q;

    logic [3:0] lane_idx [LANES];
    logic [7:0] sb_in    [LANES];
    logic [7:0] sb_out   [LANES];

    // Pass cnt covers bytes cnt*LANES .. cnt*LANES+LANES-1, byte 0 = MSB.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_idx[g] = 4'(int'(cnt_q) * LANES + g);
        assign sb_in[g]    = work_q[{~lane_idx[g], 3'b111} -: 8];

        sub_bytes_sbox u_sbox (
            .a(sb_in[g]),
            .c(sb_out[g])
        );
    end

    always_comb begin
        work_d = work_q;
        for (int l = 0; l < LANES; l++) begin
            work_d[{~lane_idx[l], 3'b111} -: 8] = sb_out[l];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            out_state_q <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        work_q     <= in_state;
                        cnt_q      <= '0;
                        state_q    <= SUB;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SUB: begin
                    work_q <= work_d;
                    if (cnt_q == LAST) begin
                        state_q     <= DONE;
                        out_state_q <= work_d;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    // in_ready rises one cycle after the result leaves.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_sub_bytes_iter.sv
// Scoreboard bench for sub_bytes_iter: GF(2^8)-derived sbox model,
// directed handshake/reset cases and random back-to-back traffic.

module tb_sub_bytes_iter;
    localparam logic [127:0] FIPS_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [127:0] ALL_63   = {16{8'h63}};
    localparam logic [127:0] ALL_16   = {16{8'h16}};

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    int cmp_cnt  = 0;
    int err_cnt  = 0;
    int n_out    = 0;
    int alt_done = 0;

    logic [7:0]   sb [256];
    logic [127:0] exp_q [$];

    sub_bytes_iter #(.LANES(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_state (in_state),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_state(out_state),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = x; bb = y;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    // sbox = affine transform of the multiplicative inverse in GF(2^8)
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3)
                  ^ rol8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[127 - 8 * i -: 8] = sb[s[127 - 8 * i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] req);
        cmp_cnt++;
        if (got !== req) begin
            err_cnt++;
            $display("FAIL %s: got %h required %h", nm, got, req);
        end
    endtask

    // Monitor: handshakes observed mid-cycle take effect at the next edge.
    always @(negedge clk) begin
        logic [127:0] e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) exp_q.push_back(ref_sub(in_state));
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    cmp_cnt++;
                    err_cnt++;
                    $display("FAIL out_unexpected: got %h required no output",
                             out_state);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_state", out_state, e);
                end
            end
        end
    end

    task automatic send(input logic [127:0] s);
        int n;
        in_valid = 1'b1;
        in_state = s;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            cmp_cnt++; err_cnt++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            cmp_cnt++; err_cnt++;
            $display("FAIL out_timeout: out_valid=%0b required 1", out_valid);
        end
    endtask

    initial begin
        int lat, base;
        logic [127:0] cap, a, b;
        build_sbox();
        rst = 1'b1; in_valid = 1'b0; in_state = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_state", out_state, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        send(FIPS_IN);
        chk("busy_sub", busy, 1);
        wait_out(lat);
        chk("lat_fips", lat, 4);
        chk("fips_value", out_state, FIPS_OUT);
        @(posedge clk); #1;

        send('0);
        wait_out(lat);
        chk("zero_value", out_state, ALL_63);
        @(posedge clk); #1;
        send('1);
        wait_out(lat);
        chk("ff_value", out_state, ALL_16);
        @(posedge clk); #1;

        out_ready = 1'b0;
        send(rnd128());
        wait_out(lat);
        cap = out_state;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_state", out_state, cap);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_rel_valid", out_valid, 0);
        chk("bp_rel_in_ready", in_ready, 1);
        out_ready = 1'b1;

        a = rnd128(); b = rnd128();
        send(a);
        in_valid = 1'b1; in_state = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(lat);
        chk("ign_value", out_state, ref_sub(a));
        @(posedge clk); #1;
        base = n_out;
        repeat (8) @(posedge clk);
        #1;
        chk("ign_no_second", n_out, base);

        send(rnd128());
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_out_state", out_state, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_in_ready", in_ready, 1);
        send(FIPS_IN);
        wait_out(lat);
        chk("mrst_lat", lat, 4);
        chk("mrst_value", out_state, FIPS_OUT);
        @(posedge clk); #1;

        base = n_out;
        for (int i = 0; i < 100; i++) send(rnd128());
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        chk("b2b_count", n_out - base, 100);

        for (int t = 0; t < 3000 && alt_done != 4; t++) @(posedge clk);
        chk("alt_done", alt_done, 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    for (genvar g = 0; g < 4; g++) begin : g_alt
        localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
        logic         rl, iv, ir, ov, bz;
        logic [127:0] is, os;

        sub_bytes_iter #(.LANES(L)) u_alt (
            .clk      (clk),
            .rst      (rl),
            .in_valid (iv),
            .in_ready (ir),
            .in_state (is),
            .out_valid(ov),
            .out_ready(1'b1),
            .out_state(os),
            .busy     (bz)
        );

        initial begin
            int n;
            logic [127:0] v [3];
            logic [127:0] e [3];
            v[0] = FIPS_IN; e[0] = FIPS_OUT;
            v[1] = '0;      e[1] = ALL_63;
            v[2] = '1;      e[2] = ALL_16;
            rl = 1'b1; iv = 1'b0; is = '0;
            repeat (3) @(posedge clk);
            #1 rl = 1'b0;
            for (int j = 0; j < 3; j++) begin
                iv = 1'b1; is = v[j];
                n = 0;
                while (!ir && n < 50) begin
                    @(posedge clk); #1;
                    n++;
                end
                @(posedge clk); #1;
                iv = 1'b0;
                n = 0;
                while (!ov && n < 50) begin
                    @(posedge clk); #1;
                    n++;
                end
                chk($sformatf("lat_L%0d_v%0d", L, j), n, 16 / L);
                chk($sformatf("val_L%0d_v%0d", L, j), os, e[j]);
                @(posedge clk); #1;
            end
            alt_done++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1);
    end
endmodule
